// File: rtl/formal_clk_rst_gen_if.sv
// Harness-side bundle for the clock/reset generator: gating and restart controls
// in, derived clocks, resets and strobes out.
interface formal_clk_rst_gen_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] gate_en;
  logic            restart;
  logic [N_CH-1:0] div_clk;
  logic [N_CH-1:0] div_rst;
  logic [N_CH-1:0] rise;
  logic            all_ready;

  modport master (
    output gate_en, restart,
    input  div_clk, div_rst, rise, all_ready
  );

  modport slave (
    input  gate_en, restart,
    output div_clk, div_rst, rise, all_ready
  );
endinterface

// File: rtl/formal_clk_rst_gen.sv
// Derives N_CH gated, divided clocks from top_clk and releases each channel's
// reset on its own period boundary once a global hold has elapsed.
module formal_clk_rst_gen #(
  parameter int                     N_CH       = 4,
  parameter int                     CNT_W      = 32,
  parameter logic [N_CH*CNT_W-1:0]  PERIOD     = {32'd1002, 32'd100, 32'd50, 32'd20},
  parameter logic [N_CH*CNT_W-1:0]  HIGH       = {32'd501, 32'd50, 32'd25, 32'd10},
  parameter int unsigned            RST_CYCLES = 1002
) (
  input  logic                top_clk,
  input  logic                top_rst,
  formal_clk_rst_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_C = CNT_W'(RST_CYCLES);

  logic [CNT_W-1:0] last_c [N_CH];
  logic [CNT_W-1:0] high_c [N_CH];

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  gate_q, gate_d;
  logic [N_CH-1:0]  div_rst_q, div_rst_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [N_CH-1:0]  wrap_c;
  logic [N_CH-1:0]  div_clk_c, rise_c;
  logic             done;

  if ((64'(RST_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_rst
    $error("RST_CYCLES does not fit in CNT_W bits");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [CNT_W-1:0] P_I = PERIOD[i*CNT_W +: CNT_W];
    localparam logic [CNT_W-1:0] H_I = HIGH[i*CNT_W +: CNT_W];

    if (P_I < CNT_W'(2)) begin : g_bad_period
      $error("channel %0d: PERIOD must be at least 2", i);
    end
    if (H_I == '0 || H_I >= P_I) begin : g_bad_high
      $error("channel %0d: HIGH must lie in 1..PERIOD-1", i);
    end

    assign last_c[i] = P_I - ONE;
    assign high_c[i] = H_I;
  end

  assign done = (rst_cnt_q == RST_C);

  // Next state: a restart is treated exactly like a wrap on every channel.
  always_comb begin
    cnt_d     = cnt_q;
    gate_d    = gate_q;
    div_rst_d = div_rst_q;
    wrap_c    = '0;
    rst_cnt_d = done ? rst_cnt_q : rst_cnt_q + ONE;
    for (int i = 0; i < N_CH; i++) begin
      wrap_c[i]    = bus.restart || (cnt_q[i] == last_c[i]);
      cnt_d[i]     = wrap_c[i] ? '0 : cnt_q[i] + ONE;
      gate_d[i]    = wrap_c[i] ? bus.gate_en[i] : gate_q[i];
      div_rst_d[i] = div_rst_q[i] & ~(done & wrap_c[i]);
    end
  end

  always_ff @(posedge top_clk or negedge top_rst) begin
    if (!top_rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      gate_q    <= '1;
      div_rst_q <= '1;
      rst_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      gate_q    <= gate_d;
      div_rst_q <= div_rst_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // Outputs decode flops only, so gating can never chop a phase short.
  always_comb begin
    div_clk_c = '0;
    rise_c    = '0;
    for (int i = 0; i < N_CH; i++) begin
      div_clk_c[i] = gate_q[i] && (cnt_q[i] < high_c[i]);
      rise_c[i]    = gate_q[i] && (cnt_q[i] == '0);
    end
  end

  assign bus.div_clk   = div_clk_c;
  assign bus.rise      = rise_c;
  assign bus.div_rst   = div_rst_q;
  assign bus.all_ready = ~|div_rst_q;

endmodule

// File: tb/tb_formal_clk_rst_gen.sv
module tb_formal_clk_rst_gen;

  logic clk = 1'b0;
  logic top_rst;
  int   edge_n = 0;
  int   epoch  = 1;
  int   n_vec  = 0;
  int   n_miss = 0;

  typedef struct {
    int         ep;
    int         n;
    logic [3:0] clk;
    logic [3:0] rise;
    logic [3:0] rst;
    logic       rdy;
  } chk_t;

  chk_t q[$];

  formal_clk_rst_gen_if #(.N_CH(4)) bus ();

  formal_clk_rst_gen dut (
    .top_clk (clk),
    .top_rst (top_rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge top_rst) begin
    if (!top_rst) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  function automatic chk_t expect_at(int ep, int n);
    int   per [4] = '{20, 50, 100, 1002};
    int   hi  [4] = '{10, 25, 50, 501};
    int   rel [4] = '{1020, 1050, 1100, 2004};
    chk_t e;
    int   c;
    int   r;
    logic g;
    e.ep = ep;
    e.n  = n;
    e.clk = '0; e.rise = '0; e.rst = '0;
    for (int i = 0; i < 4; i++) begin
      g = !(ep == 1 && i == 1 && n >= 2150 && n < 2200);
      c = (ep == 2 && n >= 1501) ? (n - 1501) % per[i] : n % per[i];
      e.clk[i]  = g && (c < hi[i]);
      e.rise[i] = g && (c == 0);
      r = (ep == 2 && i == 3) ? 1501 : rel[i];
      e.rst[i]  = (n < r);
    end
    e.rdy = (e.rst == 4'b0000);
    return e;
  endfunction

  task automatic push_range(input int ep, input int a, input int b);
    for (int n = a; n <= b; n++) q.push_back(expect_at(ep, n));
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  initial begin : monitor
    chk_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && (q[0].ep < epoch || (q[0].ep == epoch && q[0].n < edge_n))) begin
        e = q.pop_front();
        n_vec++;
        n_miss++;
        $display("FAIL missed ep%0d edge%0d: never sampled", e.ep, e.n);
      end
      if (q.size() > 0 && q[0].ep == epoch && q[0].n == edge_n) begin
        e = q.pop_front();
        n_vec++;
        if (bus.div_clk !== e.clk || bus.rise !== e.rise ||
            bus.div_rst !== e.rst || bus.all_ready !== e.rdy) begin
          n_miss++;
          $display("FAIL ep%0d edge%0d: got div_clk=%b rise=%b div_rst=%b all_ready=%b, want %b %b %b %b",
                   e.ep, e.n, bus.div_clk, bus.rise, bus.div_rst, bus.all_ready,
                   e.clk, e.rise, e.rst, e.rdy);
        end
      end
    end
  end

  initial begin : stimulus
    int budget;
    top_rst         = 1'b0;
    bus.gate_en     = 4'hF;
    bus.restart     = 1'b0;
    epoch           = 1;

    push_range(1, 0, 3);
    push_range(1, 1015, 1025);
    push_range(1, 1045, 1055);
    push_range(1, 1095, 1105);
    push_range(1, 1998, 2260);
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.div_clk !== 4'hF) begin
      n_miss++;
      $display("FAIL in reset: div_clk=%b, want 1111", bus.div_clk);
    end
    n_vec++;
    if (bus.rise !== 4'hF) begin
      n_miss++;
      $display("FAIL in reset: rise=%b, want 1111", bus.rise);
    end
    n_vec++;
    if (bus.div_rst !== 4'hF) begin
      n_miss++;
      $display("FAIL in reset: div_rst=%b, want 1111", bus.div_rst);
    end
    n_vec++;
    if (bus.all_ready !== 1'b0) begin
      n_miss++;
      $display("FAIL in reset: all_ready=%b, want 0", bus.all_ready);
    end
    top_rst = 1'b1;
    wait_edge(2110);
    bus.gate_en[1] = 1'b0;
    wait_edge(2170);
    bus.gate_en[1] = 1'b1;
    wait_edge(3003);

    push_range(2, 0, 3);
    push_range(2, 1015, 1025);
    push_range(2, 1045, 1055);
    push_range(2, 1095, 1105);
    push_range(2, 1495, 1560);
    @(posedge clk);
    #2;
    epoch   = 2;
    top_rst = 1'b0;
    #1;
    n_vec++;
    if (bus.div_clk !== 4'hF) begin
      n_miss++;
      $display("FAIL async reset: div_clk=%b, want 1111", bus.div_clk);
    end
    n_vec++;
    if (bus.rise !== 4'hF) begin
      n_miss++;
      $display("FAIL async reset: rise=%b, want 1111", bus.rise);
    end
    n_vec++;
    if (bus.div_rst !== 4'hF) begin
      n_miss++;
      $display("FAIL async reset: div_rst=%b, want 1111", bus.div_rst);
    end
    n_vec++;
    if (bus.all_ready !== 1'b0) begin
      n_miss++;
      $display("FAIL async reset: all_ready=%b, want 0", bus.all_ready);
    end
    repeat (3) @(negedge clk);
    top_rst = 1'b1;
    wait_edge(1500);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    wait_edge(1565);

    budget = 300;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    while (q.size() > 0) begin
      chk_t e;
      e = q.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL timeout ep%0d edge%0d: still pending", e.ep, e.n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    if (n_miss == 0) $display("PASS");
    else             $display("FAIL: %0d miscompares", n_miss);
    $finish;
  end

endmodule
